// File: rtl/vga_frame_ctrl.sv
// VGA timing generator: gated pixel enable, h/v counters, sync pulses and a red
// rectangle overlay whose coordinates are committed only at a frame boundary.
module vga_frame_ctrl #(
    parameter int unsigned PIX_DIV      = 10,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned H_SYNC_END   = 752,
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_END   = 492,
    parameter int unsigned V_TOTAL      = 525
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_lock,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [10:0] cfg_data,
    input  logic        cfg_commit,
    output logic        cfg_pending,
    output logic        pix_en,
    output logic        hsync,
    output logic        vsync,
    output logic        red,
    output logic        frame_start
);
    localparam int unsigned DIV_W    = 8;
    localparam int unsigned CNT_W    = 11;
    localparam int unsigned NUM_REGS = 4;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_SYNC_END);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_SYNC_END);

    // Register order is X0, X1, Y0, Y1 (index = cfg_addr)
    localparam logic [NUM_REGS-1:0][CNT_W-1:0] RECT_RST =
        {CNT_W'(100), CNT_W'(30), CNT_W'(103), CNT_W'(30)};

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             red_q, red_d;
    logic             frame_start_q, frame_start_d;
    logic             pending_q, pending_d;
    logic [NUM_REGS-1:0][CNT_W-1:0] stage_q, stage_d;
    logic [NUM_REGS-1:0][CNT_W-1:0] live_q, live_d;
    logic             h_in_rect_c, v_in_rect_c;

    // Overlay hit test on the pre-increment counters; empty when X1<=X0 or Y1<=Y0
    always_comb begin
        h_in_rect_c = (hcnt_q < H_ACT_C) && (hcnt_q >= live_q[0]) && (hcnt_q < live_q[1]);
        v_in_rect_c = (vcnt_q < V_ACT_C) && (vcnt_q >= live_q[2]) && (vcnt_q < live_q[3]);
    end

    // Divider, counters and registered video outputs
    always_comb begin
        div_d         = div_q;
        pix_en_d      = 1'b0;
        frame_start_d = 1'b0;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        red_d         = red_q;

        if (pix_en_q) begin
            hsync_d = !((hcnt_q >= HS_START_C) && (hcnt_q < HS_END_C));
            vsync_d = !((vcnt_q >= VS_START_C) && (vcnt_q < VS_END_C));
            red_d   = h_in_rect_c && v_in_rect_c;
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end

        if (pll_lock) begin
            if (div_q == DIV_LAST) begin
                div_d    = '0;
                pix_en_d = 1'b1;
                // Counters are stable in the cycle before pix_en, so this lines up with it
                frame_start_d = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d   = '0;
            hsync_d = 1'b1;
            vsync_d = 1'b1;
            red_d   = 1'b0;
        end
    end

    // Staging writes and frame-boundary commit into the live registers
    always_comb begin
        stage_d   = stage_q;
        live_d    = live_q;
        pending_d = pending_q | cfg_commit;
        if (cfg_we) begin
            stage_d[cfg_addr] = cfg_data;
        end
        if (frame_start_q && (pending_q || cfg_commit)) begin
            live_d    = stage_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            pix_en_q      <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            red_q         <= 1'b0;
            frame_start_q <= 1'b0;
            pending_q     <= 1'b0;
            stage_q       <= RECT_RST;
            live_q        <= RECT_RST;
        end else begin
            div_q         <= div_d;
            pix_en_q      <= pix_en_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            red_q         <= red_d;
            frame_start_q <= frame_start_d;
            pending_q     <= pending_d;
            stage_q       <= stage_d;
            live_q        <= live_d;
        end
    end

    assign cfg_pending = pending_q;
    assign pix_en      = pix_en_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = red_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Bench for vga_frame_ctrl: a shrunken-timing instance for frame-level checks and
// a default-parameter instance for one line of 640x480 timing.
module tb_vga_frame_ctrl;
    localparam int PD = 2, HA = 40, HSS = 41, HSE = 44, HT = 46;
    localparam int VA = 36, VSS = 36, VSE = 37, VT = 38;
    localparam int FR = PD * HT * VT;

    typedef struct {
        int x0; int x1; int y0; int y1;
        int cnt; int hmin; int hmax; int vmin; int vmax;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_lock = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [10:0] cfg_data = '0;
    logic        cfg_commit = 1'b0;
    logic        cfg_pending, pix_en, hsync, vsync, red, frame_start;

    logic        d_lock = 1'b1;
    logic        d_zero = 1'b0;
    logic [1:0]  d_addr = '0;
    logic [10:0] d_data = '0;
    logic        d_pending, d_pix_en, d_hsync, d_vsync, d_red, d_fs;

    int n_tests = 0;
    int n_fail  = 0;

    vga_frame_ctrl #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cfg_pending(cfg_pending), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .red(red), .frame_start(frame_start)
    );

    vga_frame_ctrl dut_dflt (
        .clk(clk), .rst_n(rst_n), .pll_lock(d_lock), .cfg_we(d_zero),
        .cfg_addr(d_addr), .cfg_data(d_data), .cfg_commit(d_zero),
        .cfg_pending(d_pending), .pix_en(d_pix_en), .hsync(d_hsync), .vsync(d_vsync),
        .red(d_red), .frame_start(d_fs)
    );

    always #2 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pixel tracker for the small instance; outputs seen at a pix_en belong to the previous pixel
    int bh, bv, ph, pv;
    bit prev_ok;
    int red_cnt, hs_low, vs_low, hmin, hmax, vmin, vmax;
    logic fs_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            bh = 0; bv = 0; ph = 0; pv = 0; prev_ok = 0;
        end else begin
            fs_exp = pix_en && (bh == HT - 1) && (bv == VT - 1);
            if (frame_start || fs_exp) begin
                n_tests++;
                if (frame_start !== fs_exp) begin
                    n_fail++;
                    $display("FAIL frame_start at h=%0d v=%0d: got %0b, expected %0b", bh, bv, frame_start, fs_exp);
                end
            end
            if (pix_en) begin
                if (prev_ok) begin
                    if (red) begin
                        red_cnt++;
                        if (ph < hmin) hmin = ph;
                        if (ph > hmax) hmax = ph;
                        if (pv < vmin) vmin = pv;
                        if (pv > vmax) vmax = pv;
                    end
                    if (!hsync) hs_low++;
                    if (!vsync) vs_low++;
                end
                ph = bh; pv = bv; prev_ok = 1;
                if (bh == HT - 1) begin
                    bh = 0;
                    bv = (bv == VT - 1) ? 0 : bv + 1;
                end else begin
                    bh++;
                end
            end
        end
    end

    // Default-timing tracker: pulse spacing and first-line hsync window
    int d_gap, d_gap_bad, d_pulses, d_bh, d_ph, d_hs_first, d_hs_cnt, d_vs_cnt;
    bit d_prev_ok;
    bit d_done = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            d_gap = 0; d_gap_bad = 0; d_pulses = 0; d_bh = 0; d_ph = 0;
            d_hs_first = -1; d_hs_cnt = 0; d_vs_cnt = 0; d_prev_ok = 0;
        end else begin
            d_gap++;
            if (d_pix_en) begin
                if (d_pulses > 0 && d_gap != 10) d_gap_bad++;
                d_pulses++;
                d_gap = 0;
                if (d_prev_ok && !d_hsync) begin
                    if (d_hs_first < 0) d_hs_first = d_ph;
                    d_hs_cnt++;
                end
                if (d_prev_ok && !d_vsync) d_vs_cnt++;
                d_ph = d_bh;
                d_prev_ok = 1;
                d_bh = (d_bh == 799) ? 0 : d_bh + 1;
            end
        end
    end

    initial begin : dflt_check
        int n;
        n = 0;
        wait (rst_n === 1'b1);
        while (d_pulses < 802 && n < 9000) begin
            tick();
            n++;
        end
        if (d_pulses < 802) begin
            n_tests++;
            n_fail++;
            $display("FAIL dflt_timeout: got %0d pulses, expected 802", d_pulses);
        end
        chk("dflt_pix_gap_bad", d_gap_bad, 0);
        chk("dflt_hs_first", d_hs_first, 656);
        chk("dflt_hs_len", d_hs_cnt, 96);
        chk("dflt_vs_line0", d_vs_cnt, 0);
        d_done = 1;
    end

    task automatic clr_stats();
        red_cnt = 0; hs_low = 0; vs_low = 0;
        hmin = 9999; hmax = -1; vmin = 9999; vmax = -1;
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 2 * FR);
        if (!frame_start) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_fs_timeout: got no frame_start, expected one within %0d clks", tag, 2 * FR);
        end
    endtask

    task automatic wait_pos(input string tag, input int h, input int v);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(pix_en && bh == h && bv == v) && n < 2 * FR);
        if (!(pix_en && bh == h && bv == v)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_pos_timeout: got h=%0d v=%0d, expected h=%0d v=%0d", tag, bh, bv, h, v);
        end
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_we = 1'b1;
        cfg_addr = 2'(a);
        cfg_data = 11'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic check_frame(input string tag, input vec_t e);
        chk({tag, "_red_cnt"}, red_cnt, e.cnt);
        if (e.cnt > 0) begin
            chk({tag, "_hmin"}, hmin, e.hmin);
            chk({tag, "_hmax"}, hmax, e.hmax);
            chk({tag, "_vmin"}, vmin, e.vmin);
            chk({tag, "_vmax"}, vmax, e.vmax);
        end
    endtask

    vec_t vecs[6];
    vec_t cur_exp, dflt_exp, rec_a, rec_b;

    initial begin : main
        int n;
        vecs[0] = '{5, 15, 2, 6, 40, 5, 14, 2, 5};
        vecs[1] = '{0, 40, 0, 36, 1440, 0, 39, 0, 35};
        vecs[2] = '{20, 20, 3, 9, 0, 0, 0, 0, 0};
        vecs[3] = '{10, 12, 30, 40, 12, 10, 11, 30, 35};
        vecs[4] = '{38, 2047, 35, 2047, 2, 38, 39, 35, 35};
        vecs[5] = '{25, 5, 1, 30, 0, 0, 0, 0, 0};
        dflt_exp = '{30, 103, 30, 100, 60, 30, 39, 30, 35};
        rec_a    = '{12, 20, 0, 36, 288, 12, 19, 0, 35};
        rec_b    = '{5, 20, 0, 36, 540, 5, 19, 0, 35};

        pll_lock = 1'b1;
        repeat (3) tick();
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_red", int'(red), 0);
        chk("rst_pix_en", int'(pix_en), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_pending", int'(cfg_pending), 0);

        // First frame after reset uses the default rectangle
        rst_n = 1'b1;
        clr_stats();
        wait_fs("frame0");
        check_frame("frame0", dflt_exp);
        chk("frame0_hs_low", hs_low, 3 * VT);
        chk("frame0_vs_low", vs_low, HT);
        clr_stats();

        // Each entry is committed mid-frame; that frame keeps the old rectangle
        cur_exp = dflt_exp;
        for (int i = 0; i < 6; i++) begin
            wait_pos("vec", 0, 20);
            cfg_write(0, vecs[i].x0);
            cfg_write(1, vecs[i].x1);
            cfg_write(2, vecs[i].y0);
            cfg_write(3, vecs[i].y1);
            commit();
            chk("vec_pending_set", int'(cfg_pending), 1);
            wait_fs("vec");
            check_frame($sformatf("vec%0d_prev", i), cur_exp);
            cur_exp = vecs[i];
            clr_stats();
            tick();
            chk("vec_pending_clr", int'(cfg_pending), 0);
        end

        // Commit and write in the boundary cycle: live gets the old staging value
        cfg_write(0, 12);
        cfg_write(1, 20);
        cfg_write(2, 0);
        cfg_write(3, 36);
        wait_fs("bnd");
        check_frame("vec5", cur_exp);
        cfg_commit = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 11'd5;
        clr_stats();
        tick();
        cfg_commit = 1'b0;
        cfg_we = 1'b0;
        chk("bnd_pending_clr", int'(cfg_pending), 0);
        commit();
        wait_fs("bnd_a");
        check_frame("bnd_live", rec_a);
        clr_stats();
        wait_fs("bnd_b");
        check_frame("bnd_staged", rec_b);
        clr_stats();

        // Short lock loss inside the rectangle
        wait_pos("lock_red", 11, 10);
        chk("lock_red_before", int'(red), 1);
        pll_lock = 1'b0;
        tick();
        chk("lock_red_forced", int'(red), 0);
        repeat (5) tick();
        pll_lock = 1'b1;

        // Longer lock loss inside both sync pulses
        wait_pos("lock_sync", 43, 36);
        chk("lock_hs_before", int'(hsync), 0);
        chk("lock_vs_before", int'(vsync), 0);
        pll_lock = 1'b0;
        tick();
        chk("lock_hs_forced", int'(hsync), 1);
        chk("lock_vs_forced", int'(vsync), 1);
        chk("lock_pix_en_low", int'(pix_en), 0);
        n = 0;
        repeat (50) begin
            tick();
            if (pix_en) n++;
        end
        chk("lock_pix_en_pulses", n, 0);
        chk("lock_hs_hold", int'(hsync), 1);
        pll_lock = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 2; k++) begin
            tick();
            if (pix_en) n++;
        end
        chk("lock_resume_pulses", n, 2);
        chk("lock_resume_hs", int'(hsync), 0);
        chk("lock_resume_vs", int'(vsync), 0);
        wait_fs("lock");
        clr_stats();

        // Empty rectangle staged and pending, then reset mid-line
        cfg_write(0, 30);
        cfg_write(1, 20);
        commit();
        wait_pos("rst_mid", 13, 5);
        chk("pre_rst_red", int'(red), 1);
        chk("pre_rst_pending", int'(cfg_pending), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_red", int'(red), 0);
        chk("mid_rst_pending", int'(cfg_pending), 0);
        chk("mid_rst_hsync", int'(hsync), 1);
        chk("mid_rst_pix_en", int'(pix_en), 0);
        tick();
        n = 0;
        while (!d_done && n < 20000) begin
            tick();
            n++;
        end
        if (!d_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL dflt_done_timeout: got not done, expected done");
        end
        rst_n = 1'b1;
        clr_stats();
        wait_fs("post_rst0");
        check_frame("post_rst0", dflt_exp);
        clr_stats();
        commit();
        wait_fs("post_rst1");
        check_frame("post_rst1", dflt_exp);
        clr_stats();
        wait_fs("post_rst2");
        check_frame("post_rst2", dflt_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
